// File: rtl/wordle_pkg.sv
//==============================================================================
// Module      : wordle_pkg
// Description : Shared constants, score codes and FSM state type for the
//               Wordle game controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package wordle_pkg;

    localparam int          LW       = 5;
    localparam int unsigned LETTER_A = 0;
    localparam int unsigned LETTER_Z = 25;

    localparam logic [1:0] SC_GRAY   = 2'b00;
    localparam logic [1:0] SC_YELLOW = 2'b01;
    localparam logic [1:0] SC_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_SCORE_G = 3'd2,
        ST_SCORE_Y = 3'd3,
        ST_RESULT  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wordle_scorer.sv
//==============================================================================
// Module      : wordle_scorer
// Description : Two-pass (green then yellow) guess scorer, one position per
//               cycle, with per-target-position availability flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wordle_scorer #(
    parameter int  WORD_LEN = 5,
    parameter int  LW       = 5,
    localparam int IW       = $clog2(WORD_LEN)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     phase_g,
    input  logic                     phase_y,
    input  logic [WORD_LEN*LW-1:0]   guess,
    input  logic [WORD_LEN*LW-1:0]   target,
    output logic                     last,
    output logic [2*WORD_LEN-1:0]    score_nxt
);

    import wordle_pkg::*;

    logic [IW-1:0]       idx;
    logic [WORD_LEN-1:0] avail;
    logic [WORD_LEN-1:0] avail_nxt;
    logic [1:0]          work     [WORD_LEN];
    logic [1:0]          work_nxt [WORD_LEN];
    logic [LW-1:0]       g_arr    [WORD_LEN];
    logic [LW-1:0]       t_arr    [WORD_LEN];
    logic [LW-1:0]       cur_g;
    logic                found;
    logic [IW-1:0]       hit_j;

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_unpack
        assign g_arr[i]              = guess[i*LW +: LW];
        assign t_arr[i]              = target[i*LW +: LW];
        assign score_nxt[2*i +: 2]   = work_nxt[i];
    end

    assign last  = (idx == IW'(WORD_LEN - 1));
    assign cur_g = g_arr[idx];

    // Descending scan so the lowest matching available position wins.
    always_comb begin
        found = 1'b0;
        hit_j = '0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (avail[j] && (t_arr[j] == cur_g)) begin
                found = 1'b1;
                hit_j = IW'(j);
            end
        end
    end

    always_comb begin
        work_nxt  = work;
        avail_nxt = avail;
        if (phase_g) begin
            if (cur_g == t_arr[idx]) begin
                work_nxt[idx]  = SC_GREEN;
                avail_nxt[idx] = 1'b0;
            end else begin
                work_nxt[idx]  = SC_GRAY;
            end
        end else if (phase_y) begin
            if ((work[idx] != SC_GREEN) && found) begin
                work_nxt[idx]    = SC_YELLOW;
                avail_nxt[hit_j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            avail <= '0;
            for (int i = 0; i < WORD_LEN; i++) work[i] <= SC_GRAY;
        end else if (start) begin
            idx   <= '0;
            avail <= '1;
            for (int i = 0; i < WORD_LEN; i++) work[i] <= SC_GRAY;
        end else if (phase_g || phase_y) begin
            idx   <= last ? '0 : idx + 1'b1;
            avail <= avail_nxt;
            work  <= work_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wordle_game_ctrl.sv
//==============================================================================
// Module      : wordle_game_ctrl
// Description : Parametrised Wordle game controller: letter entry buffer,
//               guess scoring sequencer and win/lose tracking.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wordle_game_ctrl #(
    parameter int  WORD_LEN    = 5,
    parameter int  MAX_GUESSES = 6,
    parameter int  LW          = wordle_pkg::LW,
    localparam int CW          = $clog2(WORD_LEN + 1),
    localparam int GW          = $clog2(MAX_GUESSES + 1)
) (
    input  logic                     Clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [WORD_LEN*LW-1:0]   target_word,
    input  logic                     letter_valid,
    input  logic [LW-1:0]            letter,
    input  logic                     backspace,
    input  logic                     submit,
    output logic [WORD_LEN*LW-1:0]   guess_word,
    output logic [CW-1:0]            cursor,
    output logic [GW-1:0]            guess_num,
    output logic [2*WORD_LEN-1:0]    score,
    output logic                     score_valid,
    output logic                     busy,
    output logic                     win,
    output logic                     lose,
    output logic [2:0]               state
);

    import wordle_pkg::*;

    state_t                  st;
    state_t                  st_nxt;
    logic [WORD_LEN*LW-1:0]  target;
    logic [2*WORD_LEN-1:0]   sc_score_nxt;
    logic                    sc_start;
    logic                    sc_last;
    logic                    entry_full;
    logic                    letter_ok;
    logic                    start_ok;
    logic                    all_green;
    logic                    final_guess;

    assign entry_full  = (cursor == CW'(WORD_LEN));
    assign letter_ok   = (32'(letter) <= LETTER_Z);
    assign sc_start    = (st == ST_ENTRY) && submit && entry_full;
    assign start_ok    = start && ((st == ST_IDLE) || (st == ST_DONE));
    assign final_guess = (guess_num == GW'(MAX_GUESSES - 1));
    assign busy        = (st == ST_SCORE_G) || (st == ST_SCORE_Y) || (st == ST_RESULT);
    assign state       = st;

    always_comb begin
        all_green = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (score[2*i +: 2] != SC_GREEN) all_green = 1'b0;
        end
    end

    wordle_scorer #(
        .WORD_LEN (WORD_LEN),
        .LW       (LW)
    ) u_scorer (
        .clk       (Clk),
        .reset_n   (reset_n),
        .start     (sc_start),
        .phase_g   (st == ST_SCORE_G),
        .phase_y   (st == ST_SCORE_Y),
        .guess     (guess_word),
        .target    (target),
        .last      (sc_last),
        .score_nxt (sc_score_nxt)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) st <= ST_IDLE;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            ST_IDLE:    if (start) st_nxt = ST_ENTRY;
            ST_ENTRY:   if (sc_start) st_nxt = ST_SCORE_G;
            ST_SCORE_G: if (sc_last) st_nxt = ST_SCORE_Y;
            ST_SCORE_Y: if (sc_last) st_nxt = ST_RESULT;
            ST_RESULT:  st_nxt = (all_green || final_guess) ? ST_DONE : ST_ENTRY;
            ST_DONE:    if (start) st_nxt = ST_ENTRY;
            default:    st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            guess_word  <= '0;
            target      <= '0;
            cursor      <= '0;
            guess_num   <= '0;
            score       <= '0;
            score_valid <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            // Final yellow step lands in score on the edge that enters RESULT.
            score_valid <= (st == ST_SCORE_Y) && sc_last;
            if (start_ok) begin
                target    <= target_word;
                cursor    <= '0;
                guess_num <= '0;
                score     <= '0;
                win       <= 1'b0;
                lose      <= 1'b0;
            end
            case (st)
                ST_ENTRY: begin
                    if (submit) begin
                        // accepted or not, submit blocks lower-priority actions
                    end else if (backspace) begin
                        if (cursor != '0) cursor <= cursor - 1'b1;
                    end else if (letter_valid && !entry_full && letter_ok) begin
                        for (int i = 0; i < WORD_LEN; i++) begin
                            if (cursor == CW'(i)) guess_word[i*LW +: LW] <= letter;
                        end
                        cursor <= cursor + 1'b1;
                    end
                end
                ST_SCORE_Y: begin
                    if (sc_last) score <= sc_score_nxt;
                end
                ST_RESULT: begin
                    guess_num <= guess_num + 1'b1;
                    if (all_green)        win    <= 1'b1;
                    else if (final_guess) lose   <= 1'b1;
                    else                  cursor <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
